dfd_trace_tail: RTL
===================

DFD_TRACE_TAIL -- requirements
Module: dfd_trace_tail

Interface
REQ-001 Parameters SHALL be: NUM_CORES_IN_PATH, default 4, core slots on the chain. DATA_WIDTH_IN_BYTES, default 16. DATA_WIDTH, default DATA_WIDTH_IN_BYTES*8. FIFO_DEPTH, default 8, entries per destination (power of 2). BP_SKID, default 4, free-entry threshold for backpressure. FLUSH_QUIET, default 16, idle cycles that end a flush.
REQ-002 Ports SHALL be, in this order:
clk  in  1  sole clock.
reset  in  1  asynchronous, active-high reset.
upstrm_tr_vld  in  NUM_CORES_IN_PATH  one-hot source core of the beat.
upstrm_tr_src  in  1  destination select: 0 = ntrace, 1 = dst.
upstrm_tr_data  in  DATA_WIDTH  beat payload.
upstrm_tr_ntrace_bp  out  1  ntrace backpressure to the chain.
upstrm_tr_dst_bp  out  1  dst backpressure to the chain.
upstrm_tr_ntrace_flush  out  1  ntrace flush request to the chain.
upstrm_tr_dst_flush  out  1  dst flush request to the chain.
upstrm_tr_enabled_srcs  out  NUM_CORES_IN_PATH  cores allowed to trace.
cfg_enabled_srcs  in  NUM_CORES_IN_PATH  CSR enable mask.
cfg_ntrace_flush_req  in  1  single-cycle ntrace flush pulse.
cfg_dst_flush_req  in  1  single-cycle dst flush pulse.
ntrace_out_vld / dst_out_vld  out  1  sink beat valid.
ntrace_out_data / dst_out_data  out  DATA_WIDTH  sink beat.
ntrace_out_core / dst_out_core  out  $clog2(NUM_CORES_IN_PATH)  source core index.
ntrace_out_rdy / dst_out_rdy  in  1  sink ready.
ntrace_flush_done / dst_flush_done  out  1  single-cycle flush-complete pulse.
err_overflow  out  2  sticky bit per destination; bit 0 = ntrace, bit 1 = dst.
err_multi_vld  out  1  sticky; set when upstrm_tr_vld is not one-hot.

Function
REQ-003 A beat SHALL arrive in any cycle with |upstrm_tr_vld. The beat SHALL be written in the same cycle into the FIFO selected by upstrm_tr_src.
REQ-004 The stored core index SHALL be the lowest set bit of upstrm_tr_vld. Any cycle with more than one bit set SHALL set err_multi_vld, and the beat SHALL still be stored.
REQ-005 An arrival at a full FIFO SHALL be dropped and SHALL set the matching err_overflow bit. The FIFO contents SHALL be unchanged.
REQ-006 Each FIFO SHALL present its head on *_out_vld/data/core. The head SHALL pop on vld & rdy. Data SHALL be visible at the sink the cycle after the write.
REQ-007 A simultaneous push and pop on a full FIFO SHALL NOT be accepted; the push SHALL be treated as an overflow. A simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged.
REQ-008 The counts SHALL be $clog2(FIFO_DEPTH)+1 bits wide. The pointers SHALL wrap modulo FIFO_DEPTH.
REQ-009 upstrm_tr_*_bp SHALL be registered. Each SHALL be 1 the cycle after the matching FIFO's count reaches at least FIFO_DEPTH-BP_SKID, and 0 otherwise.
REQ-010 upstrm_tr_enabled_srcs SHALL be cfg_enabled_srcs registered, with 1-cycle latency.
REQ-011 Each destination SHALL have an independent flush FSM with states IDLE, FLUSH and DONE.
REQ-012 IDLE -> FLUSH on the matching cfg_*_flush_req. A request received while in FLUSH or DONE SHALL be ignored.
REQ-013 In FLUSH:
- the matching upstrm_tr_*_flush SHALL be 1;
- beats SHALL still be accepted;
- a quiet counter SHALL increment each cycle with no arrival for that destination, and SHALL clear to 0 on an arrival;
- the counter SHALL saturate at FLUSH_QUIET.
REQ-014 FLUSH -> DONE when the quiet counter equals FLUSH_QUIET and the FIFO is empty.
REQ-015 DONE SHALL last exactly one cycle. During DONE, *_flush_done = 1 and the flush output = 0. The next state SHALL be IDLE.
REQ-016 A flush request arriving in the same cycle as DONE SHALL be ignored. A request arriving in the following IDLE cycle SHALL start a new flush.

Reset
REQ-017 While reset is asserted, all of the following SHALL be forced to 0 asynchronously: FIFO pointers and counts, all outputs, the sticky errors, the quiet counters and upstrm_tr_enabled_srcs. Both FSMs SHALL be forced to IDLE.
REQ-018 Assertion of reset mid-flush SHALL abort the flush with no flush_done pulse. Beats buffered at the time of reset SHALL be discarded.
REQ-019 The first beat SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-020 dfd_tn_pkg SHALL hold the flush FSM state enum (IDLE/FLUSH/DONE) and the default values of FIFO_DEPTH, BP_SKID and FLUSH_QUIET.
REQ-021 The FIFO SHALL be a sub-module, dfd_trace_tail_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, count), instantiated twice. The FSM and the backpressure logic SHALL reside in dfd_trace_tail.

Verification
REQ-022 Streaming:
- stimulus: vld=4'b0100, src=0, data=0xA5 repeated, 10 beats; ntrace_out_rdy=1;
- response: 10 beats at the ntrace sink with core=2, data=0xA5, each 1 cycle after arrival; dst sink silent; bp=0 throughout.
REQ-023 Backpressure and overflow:
- stimulus: ntrace_out_rdy=0; 9 beats with src=0;
- response: bp rises the cycle after the 4th write; the 9th beat is dropped; err_overflow=2'b01; the 8 stored beats drain in order once rdy=1.
REQ-024 Flush:
- stimulus: cfg_dst_flush_req pulse; 3 dst beats during the flush; dst_out_rdy=1;
- response: upstrm_tr_dst_flush=1 until quiet for 16 cycles after the last beat with the FIFO empty; then dst_flush_done pulses for 1 cycle.
REQ-025 Multi-valid: vld=4'b0110 -> beat stored with core=1 and err_multi_vld=1 (sticky until reset).
REQ-026 Enable mask: cfg_enabled_srcs=4'b1011 -> upstrm_tr_enabled_srcs=4'b1011 one cycle later.
REQ-027 Reset mid-flush: reset asserted while in FLUSH with 2 beats buffered -> after reset, both FIFOs empty, flush outputs 0, no flush_done pulse.

Source files
------------

// File: rtl/dfd_tn_pkg.sv
// Shared types and default sizing for the DFD trace tail: flush FSM encoding
// and the FIFO / backpressure / flush-quiet defaults.
package dfd_tn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_BP_SKID     = 4;
  localparam int DEF_FLUSH_QUIET = 16;

  // Destination indices used by the per-destination generate loop.
  localparam int DEST_NTRACE = 0;
  localparam int DEST_DST    = 1;
  localparam int NUM_DEST    = 2;

endpackage

// File: rtl/dfd_trace_tail_fifo.sv
// Power-of-two synchronous FIFO with a combinational head. A push while full
// is refused even if a pop happens in the same cycle.
module dfd_trace_tail_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = cnt;

  // Head is zeroed while empty so the sink never sees stale storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dfd_trace_tail.sv
// Tail of the trace chain: steers each beat into the ntrace or dst FIFO, drives
// registered backpressure and runs an independent flush FSM per destination.
module dfd_trace_tail
  import dfd_tn_pkg::*;
#(
  parameter int NUM_CORES_IN_PATH   = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int DATA_WIDTH          = DATA_WIDTH_IN_BYTES * 8,
  parameter int FIFO_DEPTH          = DEF_FIFO_DEPTH,
  parameter int BP_SKID             = DEF_BP_SKID,
  parameter int FLUSH_QUIET         = DEF_FLUSH_QUIET
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CORES_IN_PATH-1:0]         upstrm_tr_vld,
  input  logic                                 upstrm_tr_src,
  input  logic [DATA_WIDTH-1:0]                upstrm_tr_data,
  output logic                                 upstrm_tr_ntrace_bp,
  output logic                                 upstrm_tr_dst_bp,
  output logic                                 upstrm_tr_ntrace_flush,
  output logic                                 upstrm_tr_dst_flush,
  output logic [NUM_CORES_IN_PATH-1:0]         upstrm_tr_enabled_srcs,
  input  logic [NUM_CORES_IN_PATH-1:0]         cfg_enabled_srcs,
  input  logic                                 cfg_ntrace_flush_req,
  input  logic                                 cfg_dst_flush_req,
  output logic                                 ntrace_out_vld,
  output logic [DATA_WIDTH-1:0]                ntrace_out_data,
  output logic [$clog2(NUM_CORES_IN_PATH)-1:0] ntrace_out_core,
  input  logic                                 ntrace_out_rdy,
  output logic                                 dst_out_vld,
  output logic [DATA_WIDTH-1:0]                dst_out_data,
  output logic [$clog2(NUM_CORES_IN_PATH)-1:0] dst_out_core,
  input  logic                                 dst_out_rdy,
  output logic                                 ntrace_flush_done,
  output logic                                 dst_flush_done,
  output logic [1:0]                           err_overflow,
  output logic                                 err_multi_vld
);

  localparam int NC      = NUM_CORES_IN_PATH;
  localparam int CORE_W  = $clog2(NUM_CORES_IN_PATH);
  localparam int ENTRY_W = CORE_W + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int QW      = $clog2(FLUSH_QUIET + 1);

  logic              beat_vld;
  logic              beat_multi;
  logic [CORE_W-1:0] beat_core;
  logic [ENTRY_W-1:0] beat_entry;

  assign beat_vld   = |upstrm_tr_vld;
  assign beat_multi = |(upstrm_tr_vld & (upstrm_tr_vld - NC'(1)));
  assign beat_entry = {beat_core, upstrm_tr_data};

  // Scan downward so the lowest set bit is the one that sticks.
  always_comb begin
    beat_core = '0;
    for (int i = NC - 1; i >= 0; i--) begin
      if (upstrm_tr_vld[i]) beat_core = CORE_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_multi_vld          <= 1'b0;
      upstrm_tr_enabled_srcs <= '0;
    end else begin
      if (beat_multi) err_multi_vld <= 1'b1;
      upstrm_tr_enabled_srcs <= cfg_enabled_srcs;
    end
  end

  for (genvar d = 0; d < NUM_DEST; d++) begin : g_dest
    logic               arrive;
    logic               rdy;
    logic               req;
    logic               full;
    logic               empty;
    logic               push_ok;
    logic               pop_ok;
    logic               bp_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [ENTRY_W-1:0] head;
    flush_state_e       state_q;
    flush_state_e       state_d;
    logic [QW-1:0]      quiet_q;
    logic [QW-1:0]      quiet_d;

    assign arrive  = beat_vld & (upstrm_tr_src == 1'(d));
    assign rdy     = (d == DEST_NTRACE) ? ntrace_out_rdy : dst_out_rdy;
    assign req     = (d == DEST_NTRACE) ? cfg_ntrace_flush_req : cfg_dst_flush_req;
    assign push_ok = arrive & ~full;
    assign pop_ok  = rdy & ~empty;

    dfd_trace_tail_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (arrive),
      .wdata (beat_entry),
      .pop   (rdy),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
    );

    // Backpressure is registered from the post-update occupancy, so it is
    // visible in the cycle right after the write that crosses the threshold.
    always_comb begin
      count_next = count;
      case ({push_ok, pop_ok})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bp_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        bp_q <= (count_next >= CNT_W'(FIFO_DEPTH - BP_SKID));
        if (arrive && full) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        quiet_q <= '0;
      end else begin
        state_q <= state_d;
        quiet_q <= quiet_d;
      end
    end

    always_comb begin
      state_d = state_q;
      quiet_d = '0;
      case (state_q)
        IDLE: begin
          if (req) state_d = FLUSH;
        end
        FLUSH: begin
          if (arrive) begin
            quiet_d = '0;
          end else if (quiet_q != QW'(FLUSH_QUIET)) begin
            quiet_d = quiet_q + QW'(1);
          end else begin
            quiet_d = quiet_q;
          end
          if ((quiet_q == QW'(FLUSH_QUIET)) && empty) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign upstrm_tr_ntrace_bp    = g_dest[DEST_NTRACE].bp_q;
  assign upstrm_tr_dst_bp       = g_dest[DEST_DST].bp_q;
  assign upstrm_tr_ntrace_flush = (g_dest[DEST_NTRACE].state_q == FLUSH);
  assign upstrm_tr_dst_flush    = (g_dest[DEST_DST].state_q == FLUSH);
  assign ntrace_flush_done      = (g_dest[DEST_NTRACE].state_q == DONE);
  assign dst_flush_done         = (g_dest[DEST_DST].state_q == DONE);
  assign err_overflow           = {g_dest[DEST_DST].ovf_q, g_dest[DEST_NTRACE].ovf_q};

  assign ntrace_out_vld  = ~g_dest[DEST_NTRACE].empty;
  assign ntrace_out_data = g_dest[DEST_NTRACE].head[DATA_WIDTH-1:0];
  assign ntrace_out_core = g_dest[DEST_NTRACE].head[ENTRY_W-1:DATA_WIDTH];
  assign dst_out_vld     = ~g_dest[DEST_DST].empty;
  assign dst_out_data    = g_dest[DEST_DST].head[DATA_WIDTH-1:0];
  assign dst_out_core    = g_dest[DEST_DST].head[ENTRY_W-1:DATA_WIDTH];

endmodule
